wb_ctrl: RTL and testbench

- Writeback controller for the ONC-16 core; the sole driver of the register file write port (w_addr/w_data/we).
- Merges single-cycle ALU results and multi-cycle load returns, buffering loads in a small FIFO.
- Keeps a per-register load scoreboard so the issue stage can stall on pending destinations.

---
 rtl/wb_ctrl_pkg.sv | 32 +++
 rtl/wb_ctrl_if.sv | 43 ++++
 rtl/wb_lq_fifo.sv | 72 +++++++
 rtl/wb_ctrl.sv | 128 ++++++++++++
 tb/tb_wb_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared definitions for the ONC-16 writeback controller.
// Holds the register-file geometry, the data width and the load-return
// queue sizing, plus the packed load-queue entry type.
package wb_ctrl_pkg;

  // Register file geometry.
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned RF_ADDR_W = 3;
  localparam int unsigned RF_REG    = 8;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0]    rf_data_t;

  // Hard-wired zero register; writes to it are dropped.
  localparam rf_addr_t RF_ZERO = '0;

  // Load-return queue sizing (LQ_DEPTH must be a power of two, >= 2).
  localparam int unsigned LQ_DEPTH = 2;
  localparam int unsigned LQ_CNT_W = $clog2(LQ_DEPTH) + 1;

  typedef struct packed {
    rf_addr_t rd;
    rf_data_t data;
  } lq_entry_t;

  localparam int unsigned LQ_W = $bits(lq_entry_t);

  function automatic logic is_zero_reg(rf_addr_t addr);
    return addr == RF_ZERO;
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Writeback controller bus bundle.
// Carries the ALU result port, load issue notification, the load-return
// handshake (mem_valid/mem_ready), the register-file write port and the
// scoreboard/WAW status outputs.
//   master : issue/execute side (drives ALU, issue and memory-return inputs)
//   slave  : the writeback controller
interface wb_ctrl_if;
  import wb_ctrl_pkg::*;

  logic                  alu_valid;
  rf_addr_t              alu_rd;
  rf_data_t              alu_data;
  logic                  ld_issue;
  rf_addr_t              ld_issue_rd;
  logic                  mem_valid;
  logic                  mem_ready;
  rf_addr_t              mem_rd;
  rf_data_t              mem_data;
  rf_addr_t              rf_w_addr;
  rf_data_t              rf_w_data;
  logic                  rf_we;
  logic [RF_REG-1:0]     pend_mask;
  logic                  waw_err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_issue_rd,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    input  rf_w_addr, rf_w_data, rf_we,
    input  pend_mask, waw_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_issue_rd,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    output rf_w_addr, rf_w_data, rf_we,
    output pend_mask, waw_err
  );

endinterface

// File: rtl/wb_lq_fifo.sv
// Load-return FIFO for the writeback controller.
// Synchronous FIFO with synchronous active-high reset. Push and pop in the
// same cycle are allowed. Occupancy is held in a count register one bit
// wider than the pointers so full and empty are unambiguous.
// Ports:
//   clock, rst   : clock and synchronous reset
//   push_i       : write push_data_i (ignored when full)
//   push_data_i  : entry to enqueue
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry
//   full_o       : no free slot
//   empty_o      : no valid entry
//   count_o      : number of valid entries
module wb_lq_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [Width-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count_q says valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller for the ONC-16 core.
// Sole driver of the register-file write port. Each cycle the output
// register takes, in priority order: the ALU result, the oldest buffered
// load return, or nothing. Load returns that are not written immediately
// are queued in wb_lq_fifo. A per-register scoreboard tracks outstanding
// loads so issue can stall on pending destinations; an ALU write to a
// register with a pending load raises a one-cycle waw_err pulse.
// Optional feature macro: WB_LOAD_BYPASS_EN -- when defined, a load
// accepted while the FIFO is empty and the ALU is idle is written directly
// (latency 1) instead of being queued first (latency 2).
// Ports:
//   clock : system clock, all state on the rising edge
//   rst   : synchronous reset, active-high
//   bus   : wb_ctrl_if.slave (ALU/issue/memory inputs, RF write, status)
module wb_ctrl
  import wb_ctrl_pkg::*;
(
  input logic      clock,
  input logic      rst,
  wb_ctrl_if.slave bus
);

  lq_entry_t           lq_push_data, lq_head;
  logic                lq_push, lq_pop, lq_full, lq_empty;
  logic [LQ_CNT_W-1:0] lq_count;

  logic                mem_ready, mem_accept;

  logic                we_q, we_d;
  rf_addr_t            w_addr_q, w_addr_d;
  rf_data_t            w_data_q, w_data_d;
  logic [RF_REG-1:0]   pend_q, pend_d;
  logic                waw_q, waw_d;

  // A load written to the output register this edge, and its destination.
  logic                ld_wb;
  rf_addr_t            ld_wb_rd;

  wb_lq_fifo #(
    .Width (LQ_W),
    .Depth (LQ_DEPTH)
  ) u_lq_fifo (
    .clock       (clock),
    .rst         (rst),
    .push_i      (lq_push),
    .push_data_i (lq_push_data),
    .pop_i       (lq_pop),
    .head_o      (lq_head),
    .full_o      (lq_full),
    .empty_o     (lq_empty),
    .count_o     (lq_count)
  );

  assign mem_ready    = !rst && !lq_full;
  assign mem_accept   = bus.mem_valid && mem_ready;
  assign lq_push_data = '{rd: bus.mem_rd, data: bus.mem_data};

  // Writeback select and FIFO control.
  always_comb begin
    we_d     = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    lq_pop   = 1'b0;
    lq_push  = mem_accept;
    ld_wb    = 1'b0;
    ld_wb_rd = RF_ZERO;

    if (bus.alu_valid) begin
      we_d     = !is_zero_reg(bus.alu_rd);
      w_addr_d = bus.alu_rd;
      w_data_d = bus.alu_data;
    end else if (!lq_empty) begin
      lq_pop   = 1'b1;
      we_d     = !is_zero_reg(lq_head.rd);
      w_addr_d = lq_head.rd;
      w_data_d = lq_head.data;
      ld_wb    = 1'b1;
      ld_wb_rd = lq_head.rd;
    end
`ifdef WB_LOAD_BYPASS_EN
    else if (mem_accept) begin
      lq_push  = 1'b0;
      we_d     = !is_zero_reg(bus.mem_rd);
      w_addr_d = bus.mem_rd;
      w_data_d = bus.mem_data;
      ld_wb    = 1'b1;
      ld_wb_rd = bus.mem_rd;
    end
`endif
  end

  // Scoreboard: clear on load writeback, then set on issue so set wins.
  always_comb begin
    pend_d = pend_q;
    if (ld_wb) pend_d[ld_wb_rd] = 1'b0;
    if (bus.ld_issue && !is_zero_reg(bus.ld_issue_rd)) pend_d[bus.ld_issue_rd] = 1'b1;
    pend_d[RF_ZERO] = 1'b0;

    waw_d = bus.alu_valid && !is_zero_reg(bus.alu_rd) && pend_q[bus.alu_rd];
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      we_q     <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      pend_q   <= '0;
      waw_q    <= 1'b0;
    end else begin
      we_q     <= we_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      pend_q   <= pend_d;
      waw_q    <= waw_d;
    end
  end

  assign bus.mem_ready = mem_ready;
  assign bus.rf_we     = we_q;
  assign bus.rf_w_addr = w_addr_q;
  assign bus.rf_w_data = w_data_q;
  assign bus.pend_mask = pend_q;
  assign bus.waw_err   = waw_q;

  lq_count_bound_a: assert property (@(posedge clock) disable iff (rst)
    lq_count <= LQ_CNT_W'(LQ_DEPTH));

endmodule

// File: tb/tb_wb_ctrl.sv
module tb_wb_ctrl;
  import wb_ctrl_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  wb_ctrl_if bus ();

  wb_ctrl dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

`ifdef WB_LOAD_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Applied stimulus for the coming edge.
  logic     a_rst, a_av, a_li, a_mv;
  rf_addr_t a_ard, a_lrd, a_mrd;
  rf_data_t a_adata, a_mdata;

  // Reference model state.
  lq_entry_t         m_lq[$];
  logic [RF_REG-1:0] m_pend;
  logic              m_we, m_waw;
  rf_addr_t          m_addr;
  rf_data_t          m_data;

  typedef struct {
    logic     rst;
    logic     av;
    rf_addr_t ard;
    rf_data_t adata;
    logic     li;
    rf_addr_t lrd;
    logic     mv;
    rf_addr_t mrd;
    rf_data_t mdata;
    logic     we;
    rf_addr_t waddr;
    rf_data_t wdata;
    logic [7:0] pend;
    logic     waw;
    logic     rdy;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    a_rst = 1'b0; a_av = 1'b0; a_li = 1'b0; a_mv = 1'b0;
    a_ard = '0; a_lrd = '0; a_mrd = '0; a_adata = '0; a_mdata = '0;
  endtask

  // Spec-level model of one clock edge, using the applied inputs.
  task automatic model_edge();
    bit        rdy, acc, clr;
    rf_addr_t  clr_rd;
    lq_entry_t e;
    rdy = !a_rst && (m_lq.size() < LQ_DEPTH);
    if (a_rst) begin
      m_lq.delete();
      m_pend = '0; m_we = 1'b0; m_addr = '0; m_data = '0; m_waw = 1'b0;
      return;
    end
    acc    = a_mv && rdy;
    clr    = 1'b0;
    clr_rd = '0;
    m_waw  = a_av && (a_ard != RF_ZERO) && m_pend[a_ard];
    if (a_av) begin
      m_we = (a_ard != RF_ZERO); m_addr = a_ard; m_data = a_adata;
      if (acc) m_lq.push_back('{rd: a_mrd, data: a_mdata});
    end else if (m_lq.size() > 0) begin
      e = m_lq.pop_front();
      m_we = (e.rd != RF_ZERO); m_addr = e.rd; m_data = e.data;
      clr = 1'b1; clr_rd = e.rd;
      if (acc) m_lq.push_back('{rd: a_mrd, data: a_mdata});
    end else if (Bypass && acc) begin
      m_we = (a_mrd != RF_ZERO); m_addr = a_mrd; m_data = a_mdata;
      clr = 1'b1; clr_rd = a_mrd;
    end else begin
      m_we = 1'b0;
      if (acc) m_lq.push_back('{rd: a_mrd, data: a_mdata});
    end
    if (clr) m_pend[clr_rd] = 1'b0;
    if (a_li && a_lrd != RF_ZERO) m_pend[a_lrd] = 1'b1;
    m_pend[RF_ZERO] = 1'b0;
  endtask

  // Drive, clock one edge, update the model, compare against it.
  task automatic step();
    rst             = a_rst;
    bus.alu_valid   = a_av;
    bus.alu_rd      = a_ard;
    bus.alu_data    = a_adata;
    bus.ld_issue    = a_li;
    bus.ld_issue_rd = a_lrd;
    bus.mem_valid   = a_mv;
    bus.mem_rd      = a_mrd;
    bus.mem_data    = a_mdata;
    @(posedge clock);
    #1;
    model_edge();
    check("mdl_we", 32'(bus.rf_we), 32'(m_we));
    if (m_we || a_rst) begin
      check("mdl_addr", 32'(bus.rf_w_addr), 32'(m_addr));
      check("mdl_data", 32'(bus.rf_w_data), 32'(m_data));
    end
    check("mdl_pend", 32'(bus.pend_mask), 32'(m_pend));
    check("mdl_waw", 32'(bus.waw_err), 32'(m_waw));
    check("mdl_ready", 32'(bus.mem_ready), 32'(!a_rst && (m_lq.size() < LQ_DEPTH)));
  endtask

  initial begin
    set_idle();
    m_pend = '0; m_we = 1'b0; m_addr = '0; m_data = '0; m_waw = 1'b0;

    // rst av ard adata li lrd mv mrd mdata | we waddr wdata pend waw rdy
    vecs[0]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0};
    vecs[1]  = '{0, 1, 3, 16'h1234, 0, 0, 0, 0, 16'h0000, 1, 3, 16'h1234, 8'h00, 0, 1};
    vecs[2]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 1};
    vecs[3]  = '{0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 1};
    vecs[4]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 1};
    vecs[5]  = '{0, 0, 0, 16'h0000, 1, 4, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h10, 0, 1};
    vecs[6]  = '{0, 1, 4, 16'h00AA, 0, 0, 0, 0, 16'h0000, 1, 4, 16'h00AA, 8'h10, 1, 1};
    vecs[7]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h10, 0, 1};
    vecs[8]  = '{0, 1, 6, 16'h0606, 0, 0, 1, 1, 16'h1111, 1, 6, 16'h0606, 8'h10, 0, 1};
    vecs[9]  = '{0, 1, 7, 16'h0707, 0, 0, 1, 2, 16'h2222, 1, 7, 16'h0707, 8'h10, 0, 0};
    vecs[10] = '{0, 1, 6, 16'h0660, 0, 0, 1, 4, 16'h4444, 1, 6, 16'h0660, 8'h10, 0, 0};
    vecs[11] = '{0, 0, 0, 16'h0000, 0, 0, 1, 4, 16'h4444, 1, 1, 16'h1111, 8'h10, 0, 1};
    vecs[12] = '{0, 0, 0, 16'h0000, 0, 0, 1, 4, 16'h4444, 1, 2, 16'h2222, 8'h10, 0, 1};
    vecs[13] = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 4, 16'h4444, 8'h00, 0, 1};
    vecs[14] = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 1};

    for (int i = 0; i < 15; i++) begin
      a_rst = vecs[i].rst; a_av = vecs[i].av; a_ard = vecs[i].ard; a_adata = vecs[i].adata;
      a_li = vecs[i].li; a_lrd = vecs[i].lrd;
      a_mv = vecs[i].mv; a_mrd = vecs[i].mrd; a_mdata = vecs[i].mdata;
      step();
      check($sformatf("vec%0d_we", i), 32'(bus.rf_we), 32'(vecs[i].we));
      if (vecs[i].we || vecs[i].rst) begin
        check($sformatf("vec%0d_addr", i), 32'(bus.rf_w_addr), 32'(vecs[i].waddr));
        check($sformatf("vec%0d_data", i), 32'(bus.rf_w_data), 32'(vecs[i].wdata));
      end
      check($sformatf("vec%0d_pend", i), 32'(bus.pend_mask), 32'(vecs[i].pend));
      check($sformatf("vec%0d_waw", i), 32'(bus.waw_err), 32'(vecs[i].waw));
      check($sformatf("vec%0d_ready", i), 32'(bus.mem_ready), 32'(vecs[i].rdy));
    end

    // Load to rd 5 with ALU idle: latency depends on the bypass option.
    set_idle(); a_li = 1'b1; a_lrd = 3'd5;
    step();
    check("sb_set", 32'(bus.pend_mask), 32'h20);
    set_idle(); a_mv = 1'b1; a_mrd = 3'd5; a_mdata = 16'hBEEF;
    step();
`ifdef WB_LOAD_BYPASS_EN
    check("sb_wr_we", 32'(bus.rf_we), 32'd1);
    check("sb_wr_addr", 32'(bus.rf_w_addr), 32'd5);
    check("sb_wr_data", 32'(bus.rf_w_data), 32'hBEEF);
    check("sb_clr", 32'(bus.pend_mask), 32'h00);
`else
    check("sb_push_we", 32'(bus.rf_we), 32'd0);
    check("sb_push_pend", 32'(bus.pend_mask), 32'h20);
    set_idle();
    step();
    check("sb_wr_we", 32'(bus.rf_we), 32'd1);
    check("sb_wr_addr", 32'(bus.rf_w_addr), 32'd5);
    check("sb_wr_data", 32'(bus.rf_w_data), 32'hBEEF);
    check("sb_clr", 32'(bus.pend_mask), 32'h00);
`endif
    set_idle();
    step();
    check("sb_idle_we", 32'(bus.rf_we), 32'd0);

    // Fill the FIFO behind a busy ALU, then reset mid-operation.
    set_idle(); a_av = 1'b1; a_ard = 3'd1; a_adata = 16'h0101;
    a_li = 1'b1; a_lrd = 3'd3; a_mv = 1'b1; a_mrd = 3'd3; a_mdata = 16'h3333;
    step();
    set_idle(); a_av = 1'b1; a_ard = 3'd1; a_adata = 16'h0102;
    a_li = 1'b1; a_lrd = 3'd6; a_mv = 1'b1; a_mrd = 3'd6; a_mdata = 16'h6666;
    step();
    check("rmo_full", 32'(bus.mem_ready), 32'd0);
    check("rmo_pend", 32'(bus.pend_mask), 32'h48);
    set_idle(); a_rst = 1'b1;
    step();
    check("rmo_rst_we", 32'(bus.rf_we), 32'd0);
    check("rmo_rst_pend", 32'(bus.pend_mask), 32'h00);
    check("rmo_rst_ready", 32'(bus.mem_ready), 32'd0);
    set_idle();
    step();
    check("rmo_rel_we", 32'(bus.rf_we), 32'd0);
    check("rmo_rel_ready", 32'(bus.mem_ready), 32'd1);
    step();
    check("rmo_drained_we", 32'(bus.rf_we), 32'd0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      a_rst   = ($urandom_range(0, 99) == 0);
      a_av    = ($urandom_range(0, 2) == 0);
      a_ard   = rf_addr_t'($urandom_range(0, RF_REG - 1));
      a_adata = rf_data_t'($urandom);
      a_li    = ($urandom_range(0, 9) < 3);
      a_lrd   = rf_addr_t'($urandom_range(0, RF_REG - 1));
      a_mv    = ($urandom_range(0, 1) == 1);
      a_mrd   = rf_addr_t'($urandom_range(0, RF_REG - 1));
      a_mdata = rf_data_t'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
